market_maker_module: RTL and testbench

Single-instrument market-making quote engine. Each cycle it samples the latest trade price byte from the websocket front-end together with mid price, signed inventory, time-to-horizon and ask/bid half-spreads. It computes an inventory-skewed reservation price and bid/ask quotes. When a new trade price crosses a quote, it emits a one-cycle buy or sell order pulse to the order-entry block downstream.

---
 rtl/mm_pkg.sv | 38 +++
 rtl/mm_quote_engine.sv | 39 +++
 rtl/market_maker_module.sv | 101 ++++++++++
 tb/tb_market_maker_module.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared widths, quote bundle and saturating price helpers for the market-maker quote engine.
package mm_pkg;

    localparam int unsigned PRICE_W = 8;
    localparam int unsigned SKEW_W  = 2 * PRICE_W + 1;
    localparam int unsigned RES_W   = SKEW_W + 1;
    localparam int unsigned INV_W   = PRICE_W + 1;

    typedef logic [PRICE_W-1:0] price_t;

    typedef struct packed {
        price_t r;
        price_t ask;
        price_t bid;
    } quote_t;

    function automatic price_t sat_add(input price_t a, input price_t b);
        logic [PRICE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PRICE_W] ? '1 : sum[PRICE_W-1:0];
    endfunction

    function automatic price_t sat_sub(input price_t a, input price_t b);
        return (a < b) ? '0 : price_t'(a - b);
    endfunction

    // Clamp a signed reservation price into the unsigned price range.
    function automatic price_t clamp_res(input logic signed [RES_W-1:0] v);
        if (v[RES_W-1]) begin
            return '0;
        end
        if (|v[RES_W-2:PRICE_W]) begin
            return '1;
        end
        return v[PRICE_W-1:0];
    endfunction

endpackage

// File: rtl/mm_quote_engine.sv
// Combinational quote engine: inventory skew, reservation price and saturated bid/ask.
module mm_quote_engine
    import mm_pkg::*;
#(
    parameter int unsigned GAMMA_SHIFT = 4
) (
    input  logic [PRICE_W-1:0] s,
    input  logic [PRICE_W-1:0] q,
    input  logic [PRICE_W-1:0] t,
    input  logic [PRICE_W-1:0] delta_a,
    input  logic [PRICE_W-1:0] delta_b,
    output quote_t             quote
);

    logic signed [SKEW_W-1:0] q_ext;
    logic signed [SKEW_W-1:0] t_ext;
    logic signed [SKEW_W-1:0] prod;
    logic signed [SKEW_W-1:0] skew;
    logic signed [RES_W-1:0]  s_ext;
    logic signed [RES_W-1:0]  skew_ext;
    logic signed [RES_W-1:0]  r_wide;
    price_t                   r;

    // q is signed inventory, t is an unsigned horizon; |q*t| <= 32640 fits the 17-bit product.
    always_comb begin
        q_ext    = {{(SKEW_W - PRICE_W){q[PRICE_W-1]}}, q};
        t_ext    = {{(SKEW_W - PRICE_W){1'b0}}, t};
        prod     = q_ext * t_ext;
        skew     = prod >>> GAMMA_SHIFT;
        s_ext    = {{(RES_W - PRICE_W){1'b0}}, s};
        skew_ext = {skew[SKEW_W-1], skew};
        r_wide   = s_ext - skew_ext;
        r        = clamp_res(r_wide);
        quote.r   = r;
        quote.ask = sat_add(r, delta_a);
        quote.bid = sat_sub(r, delta_b);
    end

endmodule

// File: rtl/market_maker_module.sv
// Single-instrument market maker: registers market inputs, quotes around an inventory-skewed
// reservation price and pulses a buy/sell order when a fresh trade price crosses a quote.
module market_maker_module
    import mm_pkg::*;
#(
    parameter int unsigned GAMMA_SHIFT = 4,
    parameter int unsigned Q_MAX       = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRICE_W-1:0] websocket_data,
    input  logic [PRICE_W-1:0] s,
    input  logic [PRICE_W-1:0] q,
    input  logic [PRICE_W-1:0] t,
    input  logic [PRICE_W-1:0] delta_a,
    input  logic [PRICE_W-1:0] delta_b,
    output logic               buy_order,
    output logic               sell_order
);

    localparam logic signed [INV_W-1:0] Q_HI = INV_W'(Q_MAX);
    localparam logic signed [INV_W-1:0] Q_LO = -Q_HI;

    price_t price_q, price_d;
    price_t prev_price_q, prev_price_d;
    price_t s_q, s_d;
    price_t inv_q, inv_d;
    price_t t_q, t_d;
    price_t delta_a_q, delta_a_d;
    price_t delta_b_q, delta_b_d;
    logic   buy_order_q, buy_order_d;
    logic   sell_order_q, sell_order_d;

    logic                     tick;
    logic                     buy_cond;
    logic                     sell_cond;
    logic signed [INV_W-1:0]  inv_ext;
    quote_t                   quote;

    mm_quote_engine #(
        .GAMMA_SHIFT (GAMMA_SHIFT)
    ) u_quote_engine (
        .s       (s_q),
        .q       (inv_q),
        .t       (t_q),
        .delta_a (delta_a_q),
        .delta_b (delta_b_q),
        .quote   (quote)
    );

    // Input capture, tick detection and cross/limit decision.
    always_comb begin
        price_d      = websocket_data;
        prev_price_d = price_q;
        s_d          = s;
        inv_d        = q;
        t_d          = t;
        delta_a_d    = delta_a;
        delta_b_d    = delta_b;

        inv_ext   = {inv_q[PRICE_W-1], inv_q};
        tick      = (price_q != prev_price_q);
        buy_cond  = (price_q <= quote.bid) && (inv_ext < Q_HI);
        sell_cond = (price_q >= quote.ask) && (inv_ext > Q_LO);

        // A simultaneous cross only happens when both quotes collapse onto the price; stay flat.
        buy_order_d  = tick && buy_cond && !sell_cond;
        sell_order_d = tick && sell_cond && !buy_cond;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            price_q      <= '0;
            prev_price_q <= '0;
            s_q          <= '0;
            inv_q        <= '0;
            t_q          <= '0;
            delta_a_q    <= '0;
            delta_b_q    <= '0;
            buy_order_q  <= 1'b0;
            sell_order_q <= 1'b0;
        end else begin
            price_q      <= price_d;
            prev_price_q <= prev_price_d;
            s_q          <= s_d;
            inv_q        <= inv_d;
            t_q          <= t_d;
            delta_a_q    <= delta_a_d;
            delta_b_q    <= delta_b_d;
            buy_order_q  <= buy_order_d;
            sell_order_q <= sell_order_d;
        end
    end

    assign buy_order  = buy_order_q;
    assign sell_order = sell_order_q;

    quote_order_a: assert property (@(posedge clk) disable iff (!reset)
        (quote.bid <= quote.r) && (quote.r <= quote.ask));

endmodule

// File: tb/tb_market_maker_module.sv
// Self-checking bench for market_maker_module: directed quote scenarios plus randomized traffic
// against an arithmetic reference model of the quoting rules.
module tb_market_maker_module;

    localparam int GAMMA = 4;
    localparam int QMAX  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] websocket_data = '0;
    logic [7:0] s = '0;
    logic [7:0] q = '0;
    logic [7:0] t = '0;
    logic [7:0] delta_a = '0;
    logic [7:0] delta_b = '0;
    logic       buy_order;
    logic       sell_order;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {buy,sell}: pipe_new for the sample just driven, pipe_old one cycle older.
    logic [1:0] pipe_old = '0;
    logic [1:0] pipe_new = '0;
    logic [7:0] prev_model = '0;
    logic       exp_buy = 1'b0;
    logic       exp_sell = 1'b0;

    market_maker_module #(
        .GAMMA_SHIFT (GAMMA),
        .Q_MAX       (QMAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .websocket_data (websocket_data),
        .s              (s),
        .q              (q),
        .t              (t),
        .delta_a        (delta_a),
        .delta_b        (delta_b),
        .buy_order      (buy_order),
        .sell_order     (sell_order)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] model(input logic [7:0] p, input logic [7:0] prev,
                                         input logic [7:0] sv, input logic [7:0] qv,
                                         input logic [7:0] tv, input logic [7:0] dav,
                                         input logic [7:0] dbv);
        int qs, skew, r, ask, bid;
        logic buy, sell;
        qs   = int'($signed(qv));
        skew = (qs * int'(tv)) >>> GAMMA;
        r    = int'(sv) - skew;
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
        ask  = (r + int'(dav) > 255) ? 255 : r + int'(dav);
        bid  = (r - int'(dbv) < 0) ? 0 : r - int'(dbv);
        buy  = (int'(p) <= bid) && (qs < QMAX);
        sell = (int'(p) >= ask) && (qs > -QMAX);
        if (p == prev || (buy && sell)) return 2'b00;
        return {buy, sell};
    endfunction

    // Drive one sample on the falling edge; exp_* then holds what the outputs should show now.
    task automatic drive(input logic [7:0] p, input logic [7:0] sv, input logic [7:0] qv,
                         input logic [7:0] tv, input logic [7:0] dav, input logic [7:0] dbv);
        @(negedge clk);
        exp_buy    = pipe_old[1];
        exp_sell   = pipe_old[0];
        pipe_old   = pipe_new;
        pipe_new   = model(p, prev_model, sv, qv, tv, dav, dbv);
        prev_model = p;
        websocket_data = p;
        s       = sv;
        q       = qv;
        t       = tv;
        delta_a = dav;
        delta_b = dbv;
    endtask

    task automatic clear_model();
        pipe_old   = '0;
        pipe_new   = '0;
        prev_model = '0;
    endtask

    task automatic test_reset();
        websocket_data = 8'($urandom);
        s = 8'($urandom);
        q = 8'($urandom);
        t = 8'($urandom);
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (buy_order !== 1'b0 || sell_order !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_immediate: got buy=%b sell=%b, expected 0 0", buy_order, sell_order);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            websocket_data = 8'($urandom);
            n_checks++;
            if (buy_order !== 1'b0 || sell_order !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got buy=%b sell=%b, expected 0 0", i, buy_order, sell_order);
            end
        end
        @(negedge clk);
        websocket_data = 8'h00;
        reset = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            drive(8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            n_checks++;
            if (buy_order !== exp_buy || sell_order !== exp_sell) begin
                n_fail++;
                $display("FAIL reset_price0[%0d]: got buy=%b sell=%b, expected %b %b",
                         i, buy_order, sell_order, exp_buy, exp_sell);
            end
        end
    endtask

    // Each table entry is {price, s, q, t, delta_a, delta_b}; counts observed pulses.
    task automatic run_table(input string name, input logic [47:0] tbl[$],
                             output int buys, output int sells);
        buys = 0;
        sells = 0;
        foreach (tbl[i]) begin
            drive(tbl[i][47:40], tbl[i][39:32], tbl[i][31:24], tbl[i][23:16], tbl[i][15:8], tbl[i][7:0]);
            n_checks++;
            if (buy_order !== exp_buy || sell_order !== exp_sell) begin
                n_fail++;
                $display("FAIL %s[%0d]: got buy=%b sell=%b, expected %b %b",
                         name, i, buy_order, sell_order, exp_buy, exp_sell);
            end
            if (buy_order === 1'b1)  buys++;
            if (sell_order === 1'b1) sells++;
        end
    endtask

    task automatic test_buy_cross();
        int b, sl;
        run_table("buy_cross", '{48'h00C010050808, 48'h00C010050808, 48'hA5C010050808,
                                 48'hA5C010050808, 48'hA5C010050808, 48'hA5C010050808}, b, sl);
        n_checks++;
        if (b != 1 || sl != 0) begin
            n_fail++;
            $display("FAIL buy_cross_count: got buys=%0d sells=%0d, expected 1 0", b, sl);
        end
    endtask

    task automatic test_sell_cross();
        int b, sl;
        run_table("sell_cross", '{48'h908000000404, 48'h908000000404, 48'h908000000404,
                                  48'h7E8000000404, 48'h7E8000000404, 48'h7E8000000404}, b, sl);
        n_checks++;
        if (b != 0 || sl != 1) begin
            n_fail++;
            $display("FAIL sell_cross_count: got buys=%0d sells=%0d, expected 0 1", b, sl);
        end
    endtask

    task automatic test_negative_skew();
        int b, sl;
        run_table("neg_skew", '{48'h8A80F0100404, 48'h8A80F0100404, 48'h8A80F0100404,
                                48'h8E80F0100404, 48'h8E80F0100404, 48'h8E80F0100404}, b, sl);
        n_checks++;
        if (b != 1 || sl != 0) begin
            n_fail++;
            $display("FAIL neg_skew_count: got buys=%0d sells=%0d, expected 1 0", b, sl);
        end
    endtask

    task automatic test_saturation_limits();
        int b, sl;
        // r clamps high: sell at 0xFF with q=-99, blocked when q=-128; buys blocked at q>=100.
        run_table("saturation", '{48'hFFFA9DFF0404, 48'hFFFA9DFF0404, 48'hFEFA80FF0404,
                                  48'hFFFA80FF0404, 48'hFFFA80FF0404, 48'hFFFA80FF0404}, b, sl);
        n_checks++;
        if (b != 0 || sl != 1) begin
            n_fail++;
            $display("FAIL saturation_count: got buys=%0d sells=%0d, expected 0 1", b, sl);
        end
        run_table("limits", '{48'h108070000404, 48'h208064000404, 48'h308063000404,
                              48'hF0809C000404, 48'hE0809D000404, 48'hE0809D000404,
                              48'hE0809D000404}, b, sl);
        n_checks++;
        if (b != 1 || sl != 1) begin
            n_fail++;
            $display("FAIL limits_count: got buys=%0d sells=%0d, expected 1 1", b, sl);
        end
    endtask

    task automatic test_tie();
        int b, sl;
        run_table("tie", '{48'h808000000000, 48'h808000000000, 48'h808000000000,
                           48'h848000000404, 48'h7C8000000404, 48'h7C8000000404,
                           48'h7C8000000404}, b, sl);
        n_checks++;
        if (b != 1 || sl != 1) begin
            n_fail++;
            $display("FAIL tie_count: got buys=%0d sells=%0d, expected 1 1", b, sl);
        end
    endtask

    task automatic test_back_to_back();
        int b, sl;
        run_table("back_to_back", '{48'h108000000404, 48'h208000000404, 48'hF08000000404,
                                    48'hE08000000404, 48'hE08000000404, 48'hE08000000404}, b, sl);
        n_checks++;
        if (b != 2 || sl != 2) begin
            n_fail++;
            $display("FAIL back_to_back_count: got buys=%0d sells=%0d, expected 2 2", b, sl);
        end
    endtask

    task automatic test_reset_mid_pipeline();
        int b, sl;
        drive(8'h00, 8'hC0, 8'h10, 8'h05, 8'h08, 8'h08);
        drive(8'hA5, 8'hC0, 8'h10, 8'h05, 8'h08, 8'h08);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (buy_order !== 1'b0 || sell_order !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got buy=%b sell=%b, expected 0 0", i, buy_order, sell_order);
            end
            @(negedge clk);
        end
        websocket_data = 8'hA5;
        reset = 1'b1;
        clear_model();
        pipe_new   = model(8'hA5, 8'h00, 8'hC0, 8'h10, 8'h05, 8'h08, 8'h08);
        prev_model = 8'hA5;
        run_table("after_reset", '{48'hA5C010050808, 48'hA5C010050808, 48'hA5C010050808}, b, sl);
        n_checks++;
        if (b != 1 || sl != 0) begin
            n_fail++;
            $display("FAIL after_reset_count: got buys=%0d sells=%0d, expected 1 0", b, sl);
        end
    endtask

    task automatic test_random();
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) p = 8'($urandom);
            drive(p, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)));
            n_checks++;
            if (buy_order !== exp_buy || sell_order !== exp_sell || (buy_order && sell_order)) begin
                n_fail++;
                $display("FAIL random[%0d]: got buy=%b sell=%b, expected %b %b",
                         i, buy_order, sell_order, exp_buy, exp_sell);
            end
        end
    endtask

    initial begin
        test_reset();
        test_buy_cross();
        test_sell_cross();
        test_negative_skew();
        test_saturation_limits();
        test_tie();
        test_back_to_back();
        test_reset_mid_pipeline();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
